dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences MEM-stage loads/stores onto a multi-cycle data memory and stalls the pipeline until done.
//  Captures the request, drives the memory handshake and aligns sub-word data to byte lanes.
//  Sign/zero-extends load data per func3 and times out a hung memory.
//  Sits between the MEM-stage pipeline register and the data memory/cache.
// PARAMETERS
//  TIMEOUT   255  max cycles in ACCESS waiting for dm_busywait low; 0 = never time out
// PORTS
//  CLK          in   1   clock, all state on rising edge
//  RESET        in   1   synchronous, active-high reset
//  mem_read     in   1   load request from MEM stage, held until busywait low
//  mem_write    in   1   store request from MEM stage, held until busywait low
//  func3        in   3   RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  addr         in   32  byte address (ALU result)
//  store_data   in   32  rs2 value; low byte/half used for sb/sh
//  busywait     out  1   stall to pipeline
//  load_data    out  32  extended load result, valid in DONE
//  err          out  1   one-cycle pulse: illegal func3, timeout or trapped misalign
//  dm_read      out  1   memory read strobe
//  dm_write     out  1   memory write strobe
//  dm_addr      out  32  word address, {addr_q[31:2],2'b00}
//  dm_wdata     out  32  lane-replicated store data
//  dm_byteen    out  4   byte-lane enables for writes
//  dm_rdata     in   32  raw memory word
//  dm_busywait  in   1   memory busy; low = access completes at this edge
// BEHAVIOUR
//  Reset: state IDLE; busywait=0, load_data=0, err=0, dm_read=dm_write=0, dm_byteen=0, counter=0.
//  Reset mid-access drops dm_read/dm_write at that edge; the access is abandoned.
//  IDLE: busywait = mem_read|mem_write, combinational, same cycle. On a request edge, latch addr, func3,
//   store_data and kind into *_q, clear the counter and go ACCESS. mem_write and mem_read together: store wins.
//   Illegal func3 (011,110,111; store func3>010): no access; go DONE with err=1, load_data=0.
//  ACCESS: dm_read or dm_write held high and busywait=1. On an edge with dm_busywait=0, register
//   load_data (loads) and go DONE. With TIMEOUT!=0, counter increments each cycle;
//   counter==TIMEOUT-1 with dm_busywait still high -> DONE with err=1, load_data=0.
//  DONE: busywait=0 and strobes low, so the pipeline advances this edge. err pulses here only.
//   Next state is always IDLE, so a request still held is not re-issued.
//  Latency: request cycle + >=1 ACCESS cycle + DONE = 3 cycles minimum.
//  Store lanes, o=addr_q[1:0]: sb byteen=1<<o, wdata={4{sd[7:0]}}; sh byteen=o[1]?1100:0011,
//   wdata={2{sd[15:0]}}; sw byteen=1111, wdata=sd.
//  Load: w=dm_rdata>>(8*o); lb/lbu sign/zero-extend w[7:0]; lh/lhu w[15:0]; lw dm_rdata.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 makes no memory access;
//   ACCESS is skipped, DONE pulses err=1, load_data=0.
//  Undefined: offending low bits are cleared (half o&2'b10, word o=0); access proceeds, no err.
// STRUCTURE
//  Package dmem_pkg: funct3 localparams (F3_B/H/W/BU/HU), state encoding (IDLE/ACCESS/DONE),
//   and a byte-enable function.
//  Sub-module dmem_lane_align (combinational): offset, func3, store_data and dm_rdata in;
//   byteen, wdata and extended load word out. The FSM, counter and registers stay in the top module.
// TESTING
//  lw addr=0x100, dm_busywait high 2 cycles, rdata=0xDEADBEEF -> load_data=0xDEADBEEF, busywait
//   high 3 cycles, dm_addr=0x100.
//  lb addr=0x103, rdata=0x80112233 -> load_data=0xFFFFFF80; lbu -> 0x00000080; lhu addr=0x102 -> 0x00008011.
//  sb addr=0x201, store_data=0x000000A5 -> dm_byteen=0010, dm_wdata=0xA5A5A5A5, dm_addr=0x200, one write.
//  TIMEOUT=4, dm_busywait stuck high -> DONE after 4 ACCESS cycles, err=1 one cycle, strobes drop.
//  lw addr=0x102: with MISALIGN_TRAP_EN -> err=1, no dm_read; without -> dm_addr=0x100, data unshifted.
//  RESET in ACCESS cycle 2 -> next cycle IDLE, all outputs 0; a held mem_read then starts a fresh access.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller:
// funct3 encodings, controller state and the store byte-enable helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Byte-lane enables for a store of the given width at byte offset off.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated write
// data, plus the shifted and sign/zero-extended load word.
import dmem_pkg::*;

module dmem_lane_align (
  input  logic [1:0]  offset,
  input  logic [2:0]  func3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  byteen,
  output logic [31:0] wdata,
  output logic [31:0] load_word
);

  logic [31:0] shifted;

  assign byteen  = byte_en(func3, offset);
  assign shifted = rdata >> {offset, 3'b000};

  // Replicate the stored byte/half across all lanes; byteen selects the live one.
  always_comb begin
    case (func3)
      F3_B, F3_BU: wdata = {4{store_data[7:0]}};
      F3_H, F3_HU: wdata = {2{store_data[15:0]}};
      default:     wdata = store_data;
    endcase
  end

  // Extend the addressed byte/half of the memory word to 32 bits.
  always_comb begin
    case (func3)
      F3_B:    load_word = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_word = {24'h000000, shifted[7:0]};
      F3_H:    load_word = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_word = {16'h0000, shifted[15:0]};
      default: load_word = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: captures a load/store request,
// holds the memory strobe until the memory completes (or times out) and
// stalls the pipeline meanwhile.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses raise
// err without touching memory; otherwise the low address bits are cleared.
import dmem_pkg::*;

module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busywait,
  output logic [31:0] load_data,
  output logic        err,
  output logic        dm_read,
  output logic        dm_write,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata,
  input  logic        dm_busywait
);

  localparam int unsigned CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TLAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t          state;
  logic [31:0]     addr_q;
  logic [2:0]      func3_q;
  logic [31:0]     sd_q;
  logic            is_store_q;
  logic [CW-1:0]   count;
  logic            req_legal;
  logic            trap_hit;
  logic [1:0]      eff_off;
  logic [3:0]      lane_be;
  logic [31:0]     load_word;

  // Stores accept only b/h/w; loads additionally accept bu/hu.
  always_comb begin
    req_legal = 1'b0;
    if (mem_write) begin
      req_legal = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
    end else begin
      case (func3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: req_legal = 1'b1;
        default:                        req_legal = 1'b0;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign trap_hit = (((func3 == F3_H) || (func3 == F3_HU)) && addr[0]) ||
                    ((func3 == F3_W) && (addr[1:0] != 2'b00));

  // Trapped requests never reach ACCESS, so the raw offset is always aligned here.
  always_comb begin
    eff_off = addr_q[1:0];
  end
`else
  assign trap_hit = 1'b0;

  // Misaligned accesses are forced onto their natural boundary.
  always_comb begin
    eff_off = addr_q[1:0];
    case (func3_q)
      F3_H, F3_HU: eff_off = addr_q[1:0] & 2'b10;
      F3_W:        eff_off = 2'b00;
      default:     eff_off = addr_q[1:0];
    endcase
  end
`endif

  dmem_lane_align u_align (
    .offset     (eff_off),
    .func3      (func3_q),
    .store_data (sd_q),
    .rdata      (dm_rdata),
    .byteen     (lane_be),
    .wdata      (dm_wdata),
    .load_word  (load_word)
  );

  assign dm_addr   = {addr_q[31:2], 2'b00};
  assign dm_byteen = dm_write ? lane_be : '0;
  // IDLE stalls combinationally on a fresh request; ACCESS stalls; DONE releases.
  assign busywait  = (state == IDLE) ? (mem_read | mem_write) : (state == ACCESS);

  // Request capture, access sequencing, timeout and registered results.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      addr_q     <= '0;
      func3_q    <= '0;
      sd_q       <= '0;
      is_store_q <= 1'b0;
      count      <= '0;
      load_data  <= '0;
      err        <= 1'b0;
      dm_read    <= 1'b0;
      dm_write   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr_q     <= addr;
            func3_q    <= func3;
            sd_q       <= store_data;
            is_store_q <= mem_write;
            count      <= '0;
            if (!req_legal || trap_hit) begin
              state     <= DONE;
              err       <= 1'b1;
              load_data <= '0;
            end else begin
              state    <= ACCESS;
              dm_read  <= ~mem_write;
              dm_write <= mem_write;
            end
          end
        end
        ACCESS: begin
          if (!dm_busywait) begin
            if (!is_store_q) load_data <= load_word;
            dm_read  <= 1'b0;
            dm_write <= 1'b0;
            state    <= DONE;
          end else if ((TIMEOUT != 0) && (count == CW'(TLAST))) begin
            err       <= 1'b1;
            load_data <= '0;
            dm_read   <= 1'b0;
            dm_write  <= 1'b0;
            state     <= DONE;
          end else if (TIMEOUT != 0) begin
            count <= count + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed-vector bench for dmem_access_ctrl with a small busywait-driven memory.
module tb_dmem_access_ctrl;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, store_data;
  logic        busywait;
  logic [31:0] load_data;
  logic        err;
  logic        dm_read, dm_write;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_rdata;
  logic        dm_busywait;

  int n_tot = 0;
  int n_bad = 0;

  // Per-transaction observations
  int          r_busy, r_rd, r_wr, r_err_total;
  logic        r_done, r_err_done, r_err_after, r_strobe_after;
  logic [31:0] r_addr, r_wd, r_ld;
  logic [3:0]  r_be;

  dmem_access_ctrl #(.TIMEOUT(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .func3       (func3),
    .addr        (addr),
    .store_data  (store_data),
    .busywait    (busywait),
    .load_data   (load_data),
    .err         (err),
    .dm_read     (dm_read),
    .dm_write    (dm_write),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_byteen   (dm_byteen),
    .dm_rdata    (dm_rdata),
    .dm_busywait (dm_busywait)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, hold it until busywait drops, and record what was seen.
  // busy_n: ACCESS cycles with dm_busywait high before completion; stuck: never complete.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] word,
                        input int busy_n, input logic stuck);
    int acc;
    acc = 0;
    r_busy = 0; r_rd = 0; r_wr = 0; r_err_total = 0;
    r_done = 1'b0; r_err_done = 1'b0; r_err_after = 1'b0; r_strobe_after = 1'b0;
    r_addr = '0; r_wd = '0; r_ld = '0; r_be = '0;
    @(negedge CLK);
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; store_data = sd;
    dm_rdata = word; dm_busywait = 1'b1;
    for (int cyc = 0; cyc < 40 && !r_done; cyc++) begin
      #1;
      if (err) r_err_total++;
      if (!busywait) begin
        r_done     = 1'b1;
        r_err_done = err;
        r_ld       = load_data;
      end else begin
        r_busy++;
        if (dm_read) begin
          r_rd++;
          r_addr = dm_addr;
        end
        if (dm_write) begin
          r_wr++;
          r_addr = dm_addr;
          r_be   = dm_byteen;
          r_wd   = dm_wdata;
        end
        if (dm_read || dm_write) begin
          dm_busywait = (stuck || acc < busy_n) ? 1'b1 : 1'b0;
          acc++;
        end else begin
          dm_busywait = 1'b1;
        end
        @(negedge CLK);
      end
    end
    if (!r_done) chk("handshake_timeout", 32'd0, 32'd1);
    mem_read = 1'b0; mem_write = 1'b0; dm_busywait = 1'b1;
    @(negedge CLK);
    #1;
    r_err_after    = err;
    r_strobe_after = dm_read | dm_write | busywait;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = '0; addr = '0;
    store_data = '0; dm_rdata = '0; dm_busywait = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_busywait", {31'd0, busywait}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_strobes", {30'd0, dm_read, dm_write}, 32'd0);
    chk("rst_byteen", {28'd0, dm_byteen}, 32'd0);
    RESET = 1'b0;

    // lw 0x100, memory busy for one ACCESS cycle
    do_req(1'b1, 1'b0, F3_W, 32'h100, '0, 32'hDEADBEEF, 1, 1'b0);
    chk("lw_data", r_ld, 32'hDEADBEEF);
    chk("lw_busy_cycles", r_busy, 32'd3);
    chk("lw_dm_addr", r_addr, 32'h100);
    chk("lw_read_cycles", r_rd, 32'd2);
    chk("lw_err", {31'd0, r_err_done}, 32'd0);
    chk("lw_idle_after", {31'd0, r_strobe_after}, 32'd0);

    // Reset in ACCESS cycle 2, then the held mem_read restarts
    @(negedge CLK);
    mem_read = 1'b1; func3 = F3_W; addr = 32'h100; dm_rdata = 32'hCAFEF00D; dm_busywait = 1'b1;
    @(negedge CLK); #1;
    chk("rstacc_read1", {31'd0, dm_read}, 32'd1);
    @(negedge CLK); #1;
    chk("rstacc_read2", {31'd0, dm_read}, 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rstacc_read_drop", {30'd0, dm_read, dm_write}, 32'd0);
    chk("rstacc_load_clr", load_data, 32'd0);
    chk("rstacc_err", {31'd0, err}, 32'd0);
    chk("rstacc_byteen", {28'd0, dm_byteen}, 32'd0);
    chk("rstacc_idle_stall", {31'd0, busywait}, 32'd1);
    dm_busywait = 1'b0;
    @(negedge CLK); #1;
    chk("rstacc_fresh_read", {31'd0, dm_read}, 32'd1);
    @(negedge CLK); #1;
    chk("rstacc_done", {31'd0, busywait}, 32'd0);
    chk("rstacc_data", load_data, 32'hCAFEF00D);
    mem_read = 1'b0; dm_busywait = 1'b1;
    @(negedge CLK);

    // Sub-word loads
    do_req(1'b1, 1'b0, F3_B, 32'h103, '0, 32'h80112233, 0, 1'b0);
    chk("lb_data", r_ld, 32'hFFFFFF80);
    chk("lb_busy_cycles", r_busy, 32'd2);
    do_req(1'b1, 1'b0, F3_BU, 32'h103, '0, 32'h80112233, 0, 1'b0);
    chk("lbu_data", r_ld, 32'h00000080);
    do_req(1'b1, 1'b0, F3_HU, 32'h102, '0, 32'h80112233, 0, 1'b0);
    chk("lhu_data", r_ld, 32'h00008011);
    do_req(1'b1, 1'b0, F3_H, 32'h102, '0, 32'h80112233, 0, 1'b0);
    chk("lh_data", r_ld, 32'hFFFF8011);
    do_req(1'b1, 1'b0, F3_B, 32'h101, '0, 32'h80112233, 0, 1'b0);
    chk("lb_pos_data", r_ld, 32'h00000022);

    // Stores
    do_req(1'b0, 1'b1, F3_B, 32'h201, 32'h000000A5, '0, 0, 1'b0);
    chk("sb_byteen", {28'd0, r_be}, 32'h2);
    chk("sb_wdata", r_wd, 32'hA5A5A5A5);
    chk("sb_dm_addr", r_addr, 32'h200);
    chk("sb_writes", r_wr, 32'd1);
    chk("sb_reads", r_rd, 32'd0);
    do_req(1'b1, 1'b1, F3_H, 32'h202, 32'hFFFF1234, '0, 0, 1'b0);
    chk("sh_store_wins_reads", r_rd, 32'd0);
    chk("sh_writes", r_wr, 32'd1);
    chk("sh_byteen", {28'd0, r_be}, 32'hC);
    chk("sh_wdata", r_wd, 32'h12341234);
    do_req(1'b0, 1'b1, F3_W, 32'h300, 32'h12345678, '0, 0, 1'b0);
    chk("sw_byteen", {28'd0, r_be}, 32'hF);
    chk("sw_wdata", r_wd, 32'h12345678);

    // Hung memory with TIMEOUT=4
    do_req(1'b1, 1'b0, F3_W, 32'h400, '0, 32'h55555555, 0, 1'b1);
    chk("to_access_cycles", r_rd, 32'd4);
    chk("to_busy_cycles", r_busy, 32'd5);
    chk("to_err", {31'd0, r_err_done}, 32'd1);
    chk("to_err_pulses", r_err_total, 32'd1);
    chk("to_load_zero", r_ld, 32'd0);
    chk("to_err_after", {31'd0, r_err_after}, 32'd0);
    chk("to_idle_after", {31'd0, r_strobe_after}, 32'd0);

    // Illegal funct3
    do_req(1'b1, 1'b0, 3'b011, 32'h500, '0, 32'h77777777, 0, 1'b0);
    chk("ill_ld_err", {31'd0, r_err_done}, 32'd1);
    chk("ill_ld_reads", r_rd, 32'd0);
    chk("ill_ld_busy", r_busy, 32'd1);
    chk("ill_ld_data", r_ld, 32'd0);
    do_req(1'b0, 1'b1, F3_BU, 32'h504, 32'h1, '0, 0, 1'b0);
    chk("ill_st_err", {31'd0, r_err_done}, 32'd1);
    chk("ill_st_writes", r_wr, 32'd0);

    // Misaligned word load
    do_req(1'b1, 1'b0, F3_W, 32'h102, '0, 32'h11223344, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_err", {31'd0, r_err_done}, 32'd1);
    chk("mis_reads", r_rd, 32'd0);
    chk("mis_data", r_ld, 32'd0);
`else
    chk("mis_err", {31'd0, r_err_done}, 32'd0);
    chk("mis_dm_addr", r_addr, 32'h100);
    chk("mis_data", r_ld, 32'h11223344);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
